// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing sequencer: reset mode, per-axis
// region encoding and the mode legality check.
package vga_timing_pkg;

  localparam int unsigned DEF_H_WIDTH  = 640;
  localparam int unsigned DEF_H_PORCH  = 656;
  localparam int unsigned DEF_H_SYNCH  = 752;
  localparam int unsigned DEF_H_RAW    = 800;
  localparam int unsigned DEF_V_HEIGHT = 480;
  localparam int unsigned DEF_V_PORCH  = 490;
  localparam int unsigned DEF_V_SYNCH  = 492;
  localparam int unsigned DEF_V_RAW    = 525;

  typedef enum logic [1:0] {
    AX_ACTIVE = 2'd0,
    AX_FRONT  = 2'd1,
    AX_SYNC   = 2'd2,
    AX_BACK   = 2'd3
  } axis_state_e;

  // Region boundaries must be strictly increasing and the active span non-empty.
  function automatic logic mode_valid(input int unsigned act, input int unsigned porch,
                                      input int unsigned synch, input int unsigned raw);
    return (act != 0) && (act < porch) && (porch < synch) && (synch < raw);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: shadow mode registers, position counter with wrap and
// park, and region decode of the current position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W         = 12,
  parameter int unsigned DEF_ACT   = 640,
  parameter int unsigned DEF_PORCH = 656,
  parameter int unsigned DEF_SYNCH = 752,
  parameter int unsigned DEF_RAW   = 800
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         advance_i,
  input  logic         park_i,
  input  logic         load_i,
  input  logic [W-1:0] req_act_i,
  input  logic [W-1:0] req_porch_i,
  input  logic [W-1:0] req_synch_i,
  input  logic [W-1:0] req_raw_i,
  output logic [W-1:0] act_o,
  output axis_state_e  state_o,
  output logic         wrap_o
);

  logic [W-1:0] act_q, act_d;
  logic [W-1:0] porch_q, porch_d;
  logic [W-1:0] synch_q, synch_d;
  logic [W-1:0] raw_q, raw_d;
  logic [W-1:0] pos_q, pos_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_q   <= W'(DEF_ACT);
      porch_q <= W'(DEF_PORCH);
      synch_q <= W'(DEF_SYNCH);
      raw_q   <= W'(DEF_RAW);
      pos_q   <= W'(DEF_RAW - 1);
    end else begin
      act_q   <= act_d;
      porch_q <= porch_d;
      synch_q <= synch_d;
      raw_q   <= raw_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    act_d   = act_q;
    porch_d = porch_q;
    synch_d = synch_q;
    raw_d   = raw_q;
    if (load_i) begin
      act_d   = req_act_i;
      porch_d = req_porch_i;
      synch_d = req_synch_i;
      raw_d   = req_raw_i;
    end
  end

  assign wrap_o = (pos_q == raw_q - W'(1));

  // Park against the mode being latched this cycle so the first enabled
  // cycle sees a wrap consistent with the shadow it runs under.
  always_comb begin
    pos_d = pos_q;
    if (park_i) begin
      pos_d = raw_d - W'(1);
    end else if (advance_i) begin
      pos_d = wrap_o ? '0 : pos_q + W'(1);
    end
  end

  always_comb begin
    if (pos_q < act_q) begin
      state_o = AX_ACTIVE;
    end else if (pos_q < porch_q) begin
      state_o = AX_FRONT;
    end else if (pos_q < synch_q) begin
      state_o = AX_SYNC;
    end else begin
      state_o = AX_BACK;
    end
  end

  assign act_o = act_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA pixel-timing sequencer: source handshake strobes and sync outputs.
// Optional VGA_TIMING_SYNC_POL_EN adds programmable sync polarity inputs.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned HW       = 12,
  parameter int unsigned VW       = 12,
  parameter int unsigned H_WIDTH  = DEF_H_WIDTH,
  parameter int unsigned H_PORCH  = DEF_H_PORCH,
  parameter int unsigned H_SYNCH  = DEF_H_SYNCH,
  parameter int unsigned H_RAW    = DEF_H_RAW,
  parameter int unsigned V_HEIGHT = DEF_V_HEIGHT,
  parameter int unsigned V_PORCH  = DEF_V_PORCH,
  parameter int unsigned V_SYNCH  = DEF_V_SYNCH,
  parameter int unsigned V_RAW    = DEF_V_RAW
) (
  input  logic          i_pixclk,
  input  logic          i_reset_n,
  input  logic          i_en,
  input  logic [HW-1:0] i_hm_width,
  input  logic [HW-1:0] i_hm_porch,
  input  logic [HW-1:0] i_hm_synch,
  input  logic [HW-1:0] i_hm_raw,
  input  logic [VW-1:0] i_vm_height,
  input  logic [VW-1:0] i_vm_porch,
  input  logic [VW-1:0] i_vm_synch,
  input  logic [VW-1:0] i_vm_raw,
`ifdef VGA_TIMING_SYNC_POL_EN
  input  logic          i_hsync_pol,
  input  logic          i_vsync_pol,
`endif
  output logic          o_rd,
  output logic          o_newline,
  output logic          o_newframe,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [HW-1:0] o_width,
  output logic [VW-1:0] o_height,
  output logic          o_cfg_err
);

  logic        h_wrap, v_wrap;
  axis_state_e h_state, v_state;
  logic        req_valid, latch, load;
  logic        hpol, vpol;

  logic rd_q, rd_d, nl_q, nl_d, nf_q, nf_d;
  logic hs_q, hs_d, vs_q, vs_d, err_q, err_d;

  assign req_valid = mode_valid(32'(i_hm_width), 32'(i_hm_porch), 32'(i_hm_synch), 32'(i_hm_raw))
                  && mode_valid(32'(i_vm_height), 32'(i_vm_porch), 32'(i_vm_synch), 32'(i_vm_raw));

  // Requests are sampled at the newframe boundary, or continuously while stopped.
  assign latch = !i_en || (h_wrap && v_wrap);
  assign load  = latch && req_valid;

  vga_axis_counter #(
    .W(HW), .DEF_ACT(H_WIDTH), .DEF_PORCH(H_PORCH), .DEF_SYNCH(H_SYNCH), .DEF_RAW(H_RAW)
  ) u_h_axis (
    .clk_i       (i_pixclk),
    .rst_n_i     (i_reset_n),
    .advance_i   (i_en),
    .park_i      (!i_en),
    .load_i      (load),
    .req_act_i   (i_hm_width),
    .req_porch_i (i_hm_porch),
    .req_synch_i (i_hm_synch),
    .req_raw_i   (i_hm_raw),
    .act_o       (o_width),
    .state_o     (h_state),
    .wrap_o      (h_wrap)
  );

  vga_axis_counter #(
    .W(VW), .DEF_ACT(V_HEIGHT), .DEF_PORCH(V_PORCH), .DEF_SYNCH(V_SYNCH), .DEF_RAW(V_RAW)
  ) u_v_axis (
    .clk_i       (i_pixclk),
    .rst_n_i     (i_reset_n),
    .advance_i   (i_en && h_wrap),
    .park_i      (!i_en),
    .load_i      (load),
    .req_act_i   (i_vm_height),
    .req_porch_i (i_vm_porch),
    .req_synch_i (i_vm_synch),
    .req_raw_i   (i_vm_raw),
    .act_o       (o_height),
    .state_o     (v_state),
    .wrap_o      (v_wrap)
  );

`ifdef VGA_TIMING_SYNC_POL_EN
  logic hpol_q, vpol_q;

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hpol_q <= 1'b0;
      vpol_q <= 1'b0;
    end else if (load) begin
      hpol_q <= i_hsync_pol;
      vpol_q <= i_vsync_pol;
    end
  end

  assign hpol = hpol_q;
  assign vpol = vpol_q;
`else
  assign hpol = 1'b0;
  assign vpol = 1'b0;
`endif

  always_comb begin
    rd_d  = 1'b0;
    nl_d  = 1'b0;
    nf_d  = 1'b0;
    hs_d  = !hpol;
    vs_d  = !vpol;
    err_d = err_q;
    if (i_en) begin
      rd_d = (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);
      nl_d = h_wrap;
      nf_d = h_wrap && v_wrap;
      if (h_state == AX_SYNC) hs_d = hpol;
      if (v_state == AX_SYNC) vs_d = vpol;
    end
    if (latch) err_d = !req_valid;
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_q  <= 1'b0;
      nl_q  <= 1'b0;
      nf_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      err_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      nl_q  <= nl_d;
      nf_q  <= nf_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      err_q <= err_d;
    end
  end

  assign o_rd       = rd_q;
  assign o_newline  = nl_q;
  assign o_newframe = nf_q;
  assign o_hsync    = hs_q;
  assign o_vsync    = vs_q;
  assign o_cfg_err  = err_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: linear-frame-index reference model checked every
// cycle, plus directed checks on line/frame structure, enable and reset.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] hm_w, hm_p, hm_s, hm_r, vm_h, vm_p, vm_s, vm_r;
  logic        rd, nl, nf, hsync, vsync, cfg_err;
  logic [11:0] width, height;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode per axis {act, porch, synch, raw}, linear index in frame
  int mh[4], mv[4];
  int m_k;
  bit m_err;
  bit e_rd, e_nl, e_nf, e_hs, e_vs;

  int st_cyc, st_rd, st_hs, st_nl, st_nf, st_last_rd, st_first_hs, st_last_nl, st_last_nf, st_nf_gap;

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .i_pixclk   (clk),
    .i_reset_n  (rst_n),
    .i_en       (en),
    .i_hm_width (hm_w),
    .i_hm_porch (hm_p),
    .i_hm_synch (hm_s),
    .i_hm_raw   (hm_r),
    .i_vm_height(vm_h),
    .i_vm_porch (vm_p),
    .i_vm_synch (vm_s),
    .i_vm_raw   (vm_r),
    .o_rd       (rd),
    .o_newline  (nl),
    .o_newframe (nf),
    .o_hsync    (hsync),
    .o_vsync    (vsync),
    .o_width    (width),
    .o_height   (height),
    .o_cfg_err  (cfg_err)
  );

  function automatic bit ok_mode(input int a, input int b, input int c, input int d);
    return (a > 0) && (a < b) && (b < c) && (c < d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int g, input int h);
    hm_w = 12'(a); hm_p = 12'(b); hm_s = 12'(c); hm_r = 12'(d);
    vm_h = 12'(e); vm_p = 12'(f); vm_s = 12'(g); vm_r = 12'(h);
  endtask

  task automatic model_reset();
    mh = '{640, 656, 752, 800};
    mv = '{480, 490, 492, 525};
    m_k = 800 * 525 - 1;
    m_err = 1'b0;
    e_rd = 0; e_nl = 0; e_nf = 0; e_hs = 1; e_vs = 1;
  endtask

  // Advances the model by one clock edge using the inputs presented to it.
  task automatic model_edge();
    int hr, vr, hp, vp;
    bit last;
    hr = mh[3];
    vr = mv[3];
    hp = m_k % hr;
    vp = m_k / hr;
    last = (m_k == hr * vr - 1);
    if (en) begin
      e_rd = (hp < mh[0]) && (vp < mv[0]);
      e_nl = (hp == hr - 1);
      e_nf = last;
      e_hs = !((hp >= mh[1]) && (hp < mh[2]));
      e_vs = !((vp >= mv[1]) && (vp < mv[2]));
    end else begin
      e_rd = 0; e_nl = 0; e_nf = 0; e_hs = 1; e_vs = 1;
    end
    if (!en || last) begin
      if (ok_mode(int'(hm_w), int'(hm_p), int'(hm_s), int'(hm_r)) &&
          ok_mode(int'(vm_h), int'(vm_p), int'(vm_s), int'(vm_r))) begin
        mh = '{int'(hm_w), int'(hm_p), int'(hm_s), int'(hm_r)};
        mv = '{int'(vm_h), int'(vm_p), int'(vm_s), int'(vm_r)};
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (!en) m_k = mh[3] * mv[3] - 1;
    else     m_k = last ? 0 : m_k + 1;
  endtask

  task automatic check_cycle();
    logic [29:0] got, exp;
    got = {rd, nl, nf, hsync, vsync, cfg_err, width, height};
    exp = {e_rd, e_nl, e_nf, e_hs, e_vs, m_err, 12'(mh[0]), 12'(mv[0])};
    chk("cycle", 32'(got), 32'(exp));
  endtask

  task automatic clr_stats();
    st_cyc = 0; st_rd = 0; st_hs = 0; st_nl = 0; st_nf = 0;
    st_last_rd = -1; st_first_hs = -1; st_last_nl = -1; st_last_nf = -1; st_nf_gap = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
      if (rd) begin st_rd++; st_last_rd = st_cyc; end
      if (!hsync) begin st_hs++; if (st_first_hs < 0) st_first_hs = st_cyc; end
      if (nl) begin st_nl++; st_last_nl = st_cyc; end
      if (nf) begin
        if (st_nf > 0) st_nf_gap = st_cyc - st_last_nf;
        st_nf++;
        st_last_nf = st_cyc;
      end
      st_cyc++;
    end
  endtask

  task automatic wait_nf(input string tag, input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      run(1);
      seen = nf;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_rd(input string tag, input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      run(1);
      seen = rd;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  localparam logic [29:0] RST_VALS = {6'b000110, 12'd640, 12'd480};

  initial begin
    clr_stats();
    model_reset();
    en = 1'b1;
    set_req(640, 656, 752, 800, 480, 490, 492, 525);
    @(negedge clk);
    @(negedge clk);
    chk("rst_vals", 32'({rd, nl, nf, hsync, vsync, cfg_err, width, height}), 32'(RST_VALS));
    rst_n = 1'b1;

    // Default mode: one full line after the start-up newline/newframe pulse
    run(1);
    chk("start_pulse", 32'({rd, nl, nf}), 32'b011);
    clr_stats();
    run(800);
    chk("def_rd_line", 32'(st_rd), 32'd640);
    chk("def_hs_low", 32'(st_hs), 32'd96);
    chk("def_fporch", 32'(st_first_hs - st_last_rd - 1), 32'd16);
    chk("def_nl_pos", 32'(st_last_nl), 32'd799);

    // Small mode programmed while stopped
    en = 1'b0;
    set_req(4, 5, 6, 8, 2, 3, 4, 5);
    run(3);
    chk("small_w", 32'(width), 32'd4);
    chk("small_h", 32'(height), 32'd2);
    en = 1'b1;
    run(1);
    clr_stats();
    run(80);
    chk("small_rd", 32'(st_rd), 32'd16);
    chk("small_nl", 32'(st_nl), 32'd10);
    chk("small_nf_gap", 32'(st_nf_gap), 32'd40);

    // Invalid request mid-frame, then a valid one with a longer line
    run(7);
    set_req(4, 4, 6, 8, 2, 3, 4, 5);
    wait_nf("nf_to_err", 100);
    chk("err_set", 32'(cfg_err), 32'd1);
    chk("err_keep_w", 32'(width), 32'd4);
    set_req(4, 5, 6, 10, 2, 3, 4, 5);
    run(5);
    chk("err_hold", 32'(cfg_err), 32'd1);
    wait_nf("nf_to_clr", 100);
    chk("err_clr", 32'(cfg_err), 32'd0);
    clr_stats();
    run(10);
    chk("new_raw_nl", 32'(st_last_nl), 32'd9);

    // Enable dropped mid-line, then re-enabled
    wait_rd("rd_before_stop", 100);
    en = 1'b0;
    run(1);
    chk("idle", 32'({rd, nl, nf, hsync, vsync}), 32'b00011);
    run(4);
    en = 1'b1;
    run(1);
    chk("reen_pulse", 32'({rd, nl, nf}), 32'b011);
    run(1);
    chk("reen_rd", 32'(rd), 32'd1);

    // Asynchronous reset in the middle of an active pixel run
    run(1);
    wait_rd("rd_before_rst", 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({rd, nl, nf, hsync, vsync, cfg_err, width, height}), 32'(RST_VALS));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold", 32'({rd, nl, nf, hsync, vsync, cfg_err, width, height}), 32'(RST_VALS));
    rst_n = 1'b1;
    run(1);
    chk("rst_pulse", 32'({rd, nl, nf}), 32'b011);
    run(1);
    chk("rst_rd", 32'(rd), 32'd1);

    // Random modes, mid-frame request changes and enable toggling
    for (int it = 0; it < 40; it++) begin
      int a, b, c, d, e, f, g, h;
      a = $urandom_range(1, 6);
      b = a + $urandom_range(1, 3);
      c = b + $urandom_range(1, 3);
      d = c + $urandom_range(1, 4);
      e = $urandom_range(1, 4);
      f = e + $urandom_range(1, 2);
      g = f + $urandom_range(1, 2);
      h = g + $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) c = b;
      if ($urandom_range(0, 6) == 0) e = 0;
      set_req(a, b, c, d, e, f, g, h);
      en = ($urandom_range(0, 7) != 0);
      run($urandom_range(5, 120));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Pixel-timing sequencer that drives the frame-source handshake (rd/newline/newframe) and VGA sync outputs for the test-pattern generator and other pixel sources.
- Programmable horizontal/vertical mode registers, shadowed and applied only at frame boundaries.
- Exports the active width/height so the source's i_width/i_height track the mode actually in use.

Parameters:
HW, 12, horizontal counter/config width
VW, 12, vertical counter/config width
H_WIDTH/H_PORCH/H_SYNCH/H_RAW, 640/656/752/800, reset horizontal mode
V_HEIGHT/V_PORCH/V_SYNCH/V_RAW, 480/490/492/525, reset vertical mode

Ports:
i_pixclk  in  1  pixel clock
i_reset_n  in  1  asynchronous active-low reset
i_en  in  1  run enable
i_hm_width/i_hm_porch/i_hm_synch/i_hm_raw  in  HW each  requested active width, sync start, sync end, line total
i_vm_height/i_vm_porch/i_vm_synch/i_vm_raw  in  VW each  vertical equivalents
o_rd  out  1  pixel strobe to source
o_newline  out  1  one-cycle end-of-line pulse
o_newframe  out  1  one-cycle end-of-frame pulse
o_hsync, o_vsync  out  1  sync outputs
o_width  out  HW  active-mode width
o_height  out  VW  active-mode height
o_cfg_err  out  1  last requested mode rejected

Behaviour:
- One clock, i_pixclk; reset asynchronous, active-low (i_reset_n). All outputs registered.
- Reset state: shadow mode = parameter defaults; counters parked at (hraw-1, vraw-1).
- Reset output values: o_rd=0, o_newline=0, o_newframe=0, hsync/vsync inactive (high), o_cfg_err=0, o_width/o_height = defaults.
- Counters: hpos 0..hraw-1 wraps to 0 and advances vpos; vpos 0..vraw-1 wraps to 0. Unsigned arithmetic; comparisons at full HW/VW width.
- Per-axis state (derived from counter): ACTIVE [0,width) -> FRONT [width,porch) -> SYNC [porch,synch) -> BACK [synch,raw) -> ACTIVE.
- Output latency is 1 cycle: outputs in cycle n reflect the counter value of cycle n-1.
  - o_rd = hACTIVE && vACTIVE.
  - o_newline = (hpos==hraw-1).
  - o_newframe = o_newline && (vpos==vraw-1).
  - o_hsync low in hSYNC; o_vsync low in vSYNC.
- Because o_newline coincides with the last blank pixel, the source's line/frame reset always precedes the first o_rd of the next line/frame.
- Mode validity: 0 < width < porch < synch < raw, checked on each axis.
- Mode latch: taken when counters are at (hraw-1, vraw-1) and advancing (the newframe cycle), or every cycle while i_en=0.
  - Valid request: shadow and o_width/o_height update; o_cfg_err cleared.
  - Invalid request: shadow unchanged; o_cfg_err set. It stays set until a valid latch occurs.
  - Requests changed mid-frame have no effect until the next latch.
- i_en=0:
  - Counters re-park at (hraw-1, vraw-1) of the current shadow mode.
  - Outputs go idle on the next cycle: rd/newline/newframe 0, syncs high.
  - On i_en rising, the first enabled cycle advances from the parked state. The output cycle after it carries o_newline=o_newframe=1; o_rd starts one cycle later.
- Reset mid-frame: immediate async return to reset state; no partial pulses are emitted.
- Shadow-mode change at a frame boundary: the new hraw/vraw apply starting with counter value (0,0).

Optional Feature:
VGA_TIMING_SYNC_POL_EN
- Defined: adds input ports i_hsync_pol and i_vsync_pol (1 bit each, 1 = active-high). They are latched into the shadow with the mode; inactive level = complement.
- Undefined: no extra ports; both syncs fixed active-low, reset level high.

Decomposition:
- Package vga_timing_pkg holds:
  - default mode constants;
  - the axis state enum {ACTIVE, FRONT, SYNC, BACK};
  - a mode-valid check function.
- Natural sub-module: vga_axis_counter (counter, wrap, state decode, shadow mode regs), instantiated twice. The horizontal instance's wrap drives the vertical instance's advance.

Test Plan:
- Defaults, i_en=1 for 2 frames -> 640 o_rd per line, 307200 per frame. hsync low exactly 96 cycles starting 16 cycles after the last rd. 525 newline pulses between newframe pulses.
- Small mode requested while disabled: width 4, porch 5, synch 6, raw 8; height 2, porch 3, synch 4, raw 5. Then i_en=1 -> per line rd×4, blank, hsync×1, blank×2, newline at the 8th cycle; newframe every 40 cycles; o_width=4, o_height=2.
- Invalid request (porch=width=640) mid-frame -> at next newframe o_cfg_err=1 and timing unchanged. A valid request afterwards -> err clears at the following newframe.
- Valid mode change mid-frame -> current frame completes with old timing; first line after newframe uses new raw.
- i_en dropped mid-line -> rd/syncs idle next cycle. Re-enable -> newline+newframe pulse, then rd on the following cycle.
- i_reset_n asserted mid-ACTIVE, asynchronous to the clock edge -> all outputs at reset values immediately. Release -> sequence restarts as in the re-enable case.
